// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline: datapath defaults and write-back FSM states.
package arm_pkg;

    localparam int ARM_DATA_W     = 32;
    localparam int ARM_REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_FRESH = 2'd1,
        WB_STALE = 2'd2
    } wb_state_e;

    // Only an unfrozen edge can change the held entry; a frozen FRESH entry goes STALE.
    function automatic wb_state_e wb_next_state(
        input wb_state_e cur,
        input logic      freeze,
        input logic      valid
    );
        wb_state_e nxt;
        nxt = cur;
        if (!freeze) begin
            nxt = valid ? WB_FRESH : WB_EMPTY;
        end else if (cur == WB_FRESH) begin
            nxt = WB_STALE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// Saturating retired-instruction counter with asynchronous active-low clear.
module wb_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_mem_to_wb.sv
// MEM->WB pipeline register and write-back stage with write-once-under-freeze and retire count.
// Optional WB_TRACE_EN adds the trace_instr port and a simulation write-back trace.
//
// state    | meaning
// WB_EMPTY | no instruction held (bubble or after reset)
// WB_FRESH | instruction captured on the last edge; writes the register file this cycle
// WB_STALE | instruction already written once; held while the pipeline is frozen
module stage_mem_to_wb
    import arm_pkg::*;
#(
    parameter int DATA_W     = ARM_DATA_W,
    parameter int REG_ADDR_W = ARM_REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  valid_in,
    input  logic                  wb_en_in,
    input  logic                  mem_read_en_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     data_mem_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [31:0]           instruction_in,
`ifdef WB_TRACE_EN
    output logic [31:0]           trace_instr,
`endif
    output logic                  wb_en_out,
    output logic [REG_ADDR_W-1:0] wb_dest_out,
    output logic [DATA_W-1:0]     wb_value_out,
    output logic [CNT_W-1:0]      retired_count
);

    wb_state_e             state_q, state_d;
    logic                  wb_en_out_q, wb_en_out_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     value_q, value_d;
    logic                  retire_inc;

    always_comb begin
        state_d     = wb_next_state(state_q, freeze, valid_in);
        dest_d      = dest_q;
        value_d     = value_q;
        wb_en_out_d = 1'b0;
        if (!freeze) begin
            dest_d      = dest_in;
            value_d     = mem_read_en_in ? data_mem_in : alu_res_in;
            wb_en_out_d = valid_in & wb_en_in;
        end
    end

    // The write enable is registered so a held entry never writes twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= WB_EMPTY;
            wb_en_out_q <= 1'b0;
            dest_q      <= '0;
            value_q     <= '0;
        end else begin
            state_q     <= state_d;
            wb_en_out_q <= wb_en_out_d;
            dest_q      <= dest_d;
            value_q     <= value_d;
        end
    end

    // Count on the edge that enters FRESH, so the count tracks cycles spent in FRESH.
    assign retire_inc = (state_d == WB_FRESH);

    wb_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire_inc),
        .count (retired_count)
    );

    assign wb_en_out    = wb_en_out_q;
    assign wb_dest_out  = dest_q;
    assign wb_value_out = value_q;

`ifdef WB_TRACE_EN
    logic [31:0] instr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= '0;
        end else if (!freeze) begin
            instr_q <= instruction_in;
        end
    end

    assign trace_instr = instr_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && (state_q == WB_FRESH) && wb_en_out_q) begin
            $display("WB %h r%0d=%h", instr_q, dest_q, value_q);
        end
    end
`endif
`else
    logic unused_instr;
    assign unused_instr = ^instruction_in;
`endif

endmodule
